// File: rtl/data_memory_io_stage_pkg.sv
// Shared definitions for the data memory / IO stage.
//   - FSM state encodings (IDLE=0, WAIT=1, DONE=2)
//   - default address-map and sizing constants used as top-level parameter defaults
//   - latched request record and a small alignment helper
package data_memory_io_stage_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } dmemState_t;

  localparam int          DEF_MEMORY_DEPTH  = 64;
  localparam logic [31:0] DEF_RAM_BASE      = 32'h1001_0000;
  localparam logic [31:0] DEF_PORT_OUT_ADDR = 32'h1001_0400;
  localparam logic [31:0] DEF_PORT_IN_ADDR  = 32'h1001_0404;
  localparam int          DEF_WAIT_STATES   = 2;

  // One memory request as seen by the stage: op bits, byte address, store data.
  typedef struct packed {
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
  } dmemReq_t;

  function automatic logic isWordAligned(input logic [1:0] lowBits);
    return lowBits == 2'b00;
  endfunction

endpackage

// File: rtl/data_memory_io_stage_sync_2ff.sv
// sync_2ff: two-flop synchronizer for a bus of NBits quasi-static bits.
// Used for PortIn, which changes asynchronously to clk; adds 2 cycles of latency.
// Ports:
//   clk    in   1      clock, rising edge
//   reset  in   1      asynchronous active-low reset (both stages clear to 0)
//   d      in   NBits  asynchronous input
//   q      out  NBits  synchronized output
module data_memory_io_stage_sync_2ff #(
  parameter int NBits = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [NBits-1:0] d,
  output logic [NBits-1:0] q
);

  logic [NBits-1:0] meta;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/data_memory_io_stage.sv
// data_memory_io_stage: MIPS memory stage with wait states.
// Serves lw/sw from the datapath (Address = ALU result, WriteData = ReadData2) to an
// internal word RAM and to memory-mapped PortOut/PortIn registers. Each access runs
// IDLE -> WAIT -> DONE -> IDLE; Ready pulses for one cycle in DONE and the core holds
// its PC until then.
// Optional feature: define DMEM_ACCESS_COUNTER_EN to add a 16-bit count of completed
// non-error accesses, readable at PORT_IN_ADDR+4 and cleared by a write there.
// Ports:
//   clk        in   1   clock, rising edge
//   reset      in   1   asynchronous active-low reset
//   MemRead    in   1   load request, held until Ready
//   MemWrite   in   1   store request, held until Ready
//   Address    in   32  byte address
//   WriteData  in   32  store data
//   ReadData   out  32  load data, valid while Ready=1, 0 otherwise
//   Ready      out  1   one-cycle completion pulse
//   Busy       out  1   high in WAIT and DONE
//   AddrError  out  1   with Ready: misaligned, unmapped or illegal access
//   PortIn     in   8   external input, asynchronous to clk
//   PortOut    out  32  output port register
module data_memory_io_stage
  import data_memory_io_stage_pkg::*;
#(
  parameter int          MEMORY_DEPTH  = DEF_MEMORY_DEPTH,
  parameter logic [31:0] RAM_BASE      = DEF_RAM_BASE,
  parameter logic [31:0] PORT_OUT_ADDR = DEF_PORT_OUT_ADDR,
  parameter logic [31:0] PORT_IN_ADDR  = DEF_PORT_IN_ADDR,
  parameter int          WAIT_STATES   = DEF_WAIT_STATES
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [31:0] Address,
  input  logic [31:0] WriteData,
  output logic [31:0] ReadData,
  output logic        Ready,
  output logic        Busy,
  output logic        AddrError,
  input  logic [7:0]  PortIn,
  output logic [31:0] PortOut
);

  localparam int          AW       = $clog2(MEMORY_DEPTH);
  localparam logic [31:0] RAM_SPAN = 32'(4 * MEMORY_DEPTH);
  localparam logic [3:0]  WS       = 4'(WAIT_STATES);

  dmemState_t  state;
  logic [3:0]  waitCnt;
  dmemReq_t    reqQ;
  dmemReq_t    req;
  logic [7:0]  portInSync;
  logic [31:0] mem [MEMORY_DEPTH];

  logic        enterDone;
  logic [31:0] ramOff;
  logic        aligned, ramHit, outHit, inHit, cntHit;
  logic        accErr;
  logic [31:0] rdData;
  logic        commitWr;

  data_memory_io_stage_sync_2ff #(.NBits(8)) uPortInSync (
    .clk   (clk),
    .reset (reset),
    .d     (PortIn),
    .q     (portInSync)
  );

  // In IDLE the live requester inputs drive decode so a zero-wait-state access can
  // commit on the same edge that accepts it; afterwards only the latched copy counts.
  always_comb begin
    req = reqQ;
    if (state == S_IDLE) begin
      req.rd    = MemRead;
      req.wr    = MemWrite;
      req.addr  = Address;
      req.wdata = WriteData;
    end
  end

  // The edge that moves the FSM into DONE is the commit edge.
  assign enterDone = ((state == S_IDLE) && (MemRead || MemWrite) && (WS == 4'd0)) ||
                     ((state == S_WAIT) && (waitCnt == 4'd1));

`ifdef DMEM_ACCESS_COUNTER_EN
  logic [15:0] accessCnt;
`endif

  // Address decode and read mux. Anything that is not a legal single-op access to a
  // mapped location is an error: no side effect, ReadData stays 0.
  always_comb begin
    ramOff  = req.addr - RAM_BASE;
    aligned = isWordAligned(req.addr[1:0]);
    ramHit  = aligned && (req.addr >= RAM_BASE) && (ramOff < RAM_SPAN);
    outHit  = aligned && (req.addr == PORT_OUT_ADDR);
    inHit   = aligned && (req.addr == PORT_IN_ADDR);
`ifdef DMEM_ACCESS_COUNTER_EN
    cntHit  = aligned && (req.addr == PORT_IN_ADDR + 32'd4);
`else
    cntHit  = 1'b0;
`endif
    accErr  = 1'b1;
    rdData  = '0;
    if (req.rd && !req.wr) begin
      if (ramHit) begin
        accErr = 1'b0;
        rdData = mem[ramOff[AW+1:2]];
      end else if (outHit) begin
        accErr = 1'b0;
        rdData = PortOut;
      end else if (inHit) begin
        accErr = 1'b0;
        rdData = {24'b0, portInSync};
      end
`ifdef DMEM_ACCESS_COUNTER_EN
      else if (cntHit) begin
        accErr = 1'b0;
        rdData = {16'b0, accessCnt};
      end
`endif
    end else if (req.wr && !req.rd) begin
      // PortIn is read-only, so a store there stays an error.
      accErr = !(ramHit || outHit || cntHit);
    end
  end

  assign commitWr = enterDone && !accErr && req.wr;

  // RAM contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (commitWr && ramHit)
      mem[ramOff[AW+1:2]] <= req.wdata;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= S_IDLE;
      waitCnt   <= '0;
      reqQ      <= '0;
      ReadData  <= '0;
      Ready     <= 1'b0;
      Busy      <= 1'b0;
      AddrError <= 1'b0;
      PortOut   <= '0;
    end else begin
      ReadData  <= '0;
      Ready     <= 1'b0;
      AddrError <= 1'b0;

      if (enterDone) begin
        Ready     <= 1'b1;
        Busy      <= 1'b1;
        AddrError <= accErr;
        ReadData  <= rdData;
        if (commitWr && outHit)
          PortOut <= req.wdata;
      end

      unique case (state)
        S_IDLE: begin
          if (MemRead || MemWrite) begin
            reqQ    <= req;
            waitCnt <= WS;
            if (WS == 4'd0) begin
              state <= S_DONE;
            end else begin
              state <= S_WAIT;
              Busy  <= 1'b1;
            end
          end
        end
        S_WAIT: begin
          waitCnt <= waitCnt - 4'd1;
          if (waitCnt == 4'd1)
            state <= S_DONE;
        end
        S_DONE: begin
          state <= S_IDLE;
          Busy  <= 1'b0;
        end
        default: begin
          state <= S_IDLE;
          Busy  <= 1'b0;
        end
      endcase
    end
  end

`ifdef DMEM_ACCESS_COUNTER_EN
  // Counts completed good accesses; a store to the counter clears it and is not counted.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      accessCnt <= '0;
    end else if (enterDone && !accErr) begin
      if (req.wr && cntHit)
        accessCnt <= '0;
      else
        accessCnt <= accessCnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_data_memory_io_stage.sv
// Bench for data_memory_io_stage. Two instances: the default 2-wait-state build
// (channel 0) and a zero-wait-state build (channel 1). The driver computes each
// expected response from a behavioural model of the address map and pushes it to a
// per-channel queue; an independent monitor pops and compares on every Ready pulse.
module tb_data_memory_io_stage;

  localparam logic [31:0] RAM_BASE = 32'h1001_0000;
  localparam logic [31:0] PORT_OUT = 32'h1001_0400;
  localparam logic [31:0] PORT_IN  = 32'h1001_0404;
  localparam int          DEPTH    = 64;

  typedef struct {
    logic [31:0] data;
    logic        err;
    logic [31:0] pout;
    int          cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        mr [2];
  logic        mw [2];
  logic [31:0] addr [2];
  logic [31:0] wd [2];
  logic [31:0] rdData [2];
  logic        rdy [2];
  logic        busy [2];
  logic        aerr [2];
  logic [31:0] pout [2];
  logic [7:0]  portIn;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  bit atReady [2];

  exp_t q0[$];
  exp_t q1[$];

  // behavioural model state
  logic [31:0] ramM [2][DEPTH];
  logic [31:0] poutM [2];
  logic [15:0] cntM [2];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  data_memory_io_stage #(.WAIT_STATES(2)) dut (
    .clk(clk), .reset(rst), .MemRead(mr[0]), .MemWrite(mw[0]), .Address(addr[0]),
    .WriteData(wd[0]), .ReadData(rdData[0]), .Ready(rdy[0]), .Busy(busy[0]),
    .AddrError(aerr[0]), .PortIn(portIn), .PortOut(pout[0])
  );

  data_memory_io_stage #(.WAIT_STATES(0)) dut0 (
    .clk(clk), .reset(rst), .MemRead(mr[1]), .MemWrite(mw[1]), .Address(addr[1]),
    .WriteData(wd[1]), .ReadData(rdData[1]), .Ready(rdy[1]), .Busy(busy[1]),
    .AddrError(aerr[1]), .PortIn(portIn), .PortOut(pout[1])
  );

  task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %b, expected %b (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Address-map rules applied directly; updates model state for stores.
  function automatic void predict(input int ch, input logic rd, input logic wr,
                                  input logic [31:0] a, input logic [31:0] w,
                                  output logic [31:0] d, output logic e);
    bit clr;
    int idx;
    clr = 0;
    d = '0;
    e = 1'b1;
    if (!(rd && wr) && a[1:0] == 2'b00) begin
      if (a >= RAM_BASE && a < RAM_BASE + 32'(4 * DEPTH)) begin
        idx = int'((a - RAM_BASE) >> 2);
        e = 1'b0;
        if (rd) d = ramM[ch][idx];
        else    ramM[ch][idx] = w;
      end else if (a == PORT_OUT) begin
        e = 1'b0;
        if (rd) d = poutM[ch];
        else    poutM[ch] = w;
      end else if (a == PORT_IN) begin
        if (rd) begin
          e = 1'b0;
          d = {24'b0, portIn};
        end
      end
`ifdef DMEM_ACCESS_COUNTER_EN
      else if (a == PORT_IN + 32'd4) begin
        e = 1'b0;
        if (rd) d = {16'b0, cntM[ch]};
        else begin
          cntM[ch] = '0;
          clr = 1;
        end
      end
`endif
    end
    if (!e && !clr) cntM[ch] = cntM[ch] + 16'd1;
  endfunction

  // Issue one access on a channel (called at a negedge) and hold it until Ready.
  task automatic access(input int ch, input logic rd, input logic wr,
                        input logic [31:0] a, input logic [31:0] w);
    exp_t e;
    logic [31:0] d;
    logic er;
    int n;
    predict(ch, rd, wr, a, w, d, er);
    e.data = d;
    e.err  = er;
    e.pout = poutM[ch];
    // issued during a Ready cycle -> accepted one edge later (DONE ignores inputs)
    e.cyc  = (atReady[ch] ? cyc + 2 : cyc + 1) + (ch == 0 ? 2 : 0);
    if (ch == 0) q0.push_back(e);
    else         q1.push_back(e);
    mr[ch] = rd;
    mw[ch] = wr;
    addr[ch] = a;
    wd[ch] = w;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!rdy[ch] && n < 50);
    if (!rdy[ch]) begin
      checks++;
      failures++;
      $display("FAIL ready_timeout ch%0d: no Ready after %0d cycles, expected within %0d", ch, n, 3);
    end
    atReady[ch] = 1;
  endtask

  task automatic idle(input int ch, input int n);
    mr[ch] = 1'b0;
    mw[ch] = 1'b0;
    repeat (n) @(negedge clk);
    atReady[ch] = 0;
  endtask

  task automatic score(input int ch, input exp_t e);
    chk32($sformatf("readdata_ch%0d", ch), rdData[ch], e.data);
    chk1($sformatf("addrerror_ch%0d", ch), aerr[ch], e.err);
    chk32($sformatf("portout_ch%0d", ch), pout[ch], e.pout);
    chk32($sformatf("latency_cycle_ch%0d", ch), 32'(cyc), 32'(e.cyc));
    chk1($sformatf("busy_ch%0d", ch), busy[ch], 1'b1);
  endtask

  // Monitor: every Ready pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst === 1'b1) begin
      if (rdy[0] === 1'b1) begin
        if (q0.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_ready ch0: Ready=1, expected no outstanding access");
        end else score(0, q0.pop_front());
      end
      if (rdy[1] === 1'b1) begin
        if (q1.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_ready ch1: Ready=1, expected no outstanding access");
        end else score(1, q1.pop_front());
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int sel, idx;
    logic rd, wr;
    logic [31:0] a, w;

    rst = 1'b0;
    portIn = 8'h00;
    for (int c = 0; c < 2; c++) begin
      mr[c] = 0; mw[c] = 0; addr[c] = '0; wd[c] = '0;
      poutM[c] = '0; cntM[c] = '0; atReady[c] = 0;
    end

    // reset state
    @(posedge clk);
    #2;
    for (int c = 0; c < 2; c++) begin
      chk32("reset_readdata", rdData[c], 32'h0);
      chk1("reset_ready", rdy[c], 1'b0);
      chk1("reset_busy", busy[c], 1'b0);
      chk1("reset_addrerror", aerr[c], 1'b0);
      chk32("reset_portout", pout[c], 32'h0);
    end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // fill RAM so every later read has a known value
    for (int i = 0; i < DEPTH; i++) access(0, 0, 1, RAM_BASE + 32'(4 * i), $urandom);
    idle(0, 1);

    // sw/lw RAM
    access(0, 0, 1, RAM_BASE + 32'd8, 32'hDEAD_BEEF);
    access(0, 1, 0, RAM_BASE + 32'd8, 32'h0);
    // PortOut write then read-back
    access(0, 0, 1, PORT_OUT, 32'h0000_005A);
    access(0, 1, 0, PORT_OUT, 32'h0);
    idle(0, 1);
    // PortIn through the synchronizer
    portIn = 8'hC3;
    idle(0, 3);
    access(0, 1, 0, PORT_IN, 32'h0);
    // error cases: misaligned, unmapped, both ops, store to PortIn
    access(0, 1, 0, RAM_BASE + 32'd2, 32'h0);
    access(0, 1, 0, 32'h0, 32'h0);
    access(0, 1, 1, RAM_BASE + 32'd12, 32'hFFFF_FFFF);
    access(0, 0, 1, PORT_IN, 32'h77);
    access(0, 1, 0, RAM_BASE + 32'd12, 32'h0);
    access(0, 1, 0, PORT_OUT, 32'h0);
    // access counter (unmapped unless the feature is built in)
    access(0, 0, 1, PORT_IN + 32'd4, 32'h0);
    for (int i = 0; i < 3; i++) access(0, 1, 0, RAM_BASE + 32'(4 * i), 32'h0);
    access(0, 1, 0, PORT_IN + 32'd4, 32'h0);

    // randomized traffic
    for (int i = 0; i < 200; i++) begin
      sel = $urandom_range(0, 15);
      idx = $urandom_range(0, DEPTH - 1);
      w = $urandom;
      rd = 1; wr = 0;
      a = RAM_BASE + 32'(4 * idx);
      case (sel)
        0, 1, 2, 3, 4, 5: ;
        6, 7, 8: begin rd = 0; wr = 1; end
        9:  begin rd = 0; wr = 1; a = PORT_OUT; end
        10: a = PORT_OUT;
        11: a = PORT_IN;
        12: a = a + 32'($urandom_range(1, 3));
        13: a = 32'h2000_0000 | ($urandom & 32'h00FF_FFFC);
        14: wr = 1;
        default: begin
          a = PORT_IN + 32'd4;
          if ($urandom_range(0, 3) == 0) begin rd = 0; wr = 1; end
        end
      endcase
      if ($urandom_range(0, 9) == 0) begin
        idle(0, 1);
        portIn = 8'($urandom);
        idle(0, 3);
      end
      access(0, rd, wr, a, w);
    end
    idle(0, 1);

    // reset asserted while a store is waiting: no commit, no Ready
    mw[0] = 1'b1;
    addr[0] = RAM_BASE;
    wd[0] = 32'd1234;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk1("midreset_busy", busy[0], 1'b0);
    chk1("midreset_ready", rdy[0], 1'b0);
    chk32("midreset_portout", pout[0], 32'h0);
    mw[0] = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    for (int c = 0; c < 2; c++) begin
      poutM[c] = '0; cntM[c] = '0; atReady[c] = 0;
    end
    idle(0, 3);
    access(0, 1, 0, RAM_BASE, 32'h0);
    idle(0, 1);

    // zero wait states: back-to-back loads complete every second cycle
    access(1, 0, 1, RAM_BASE + 32'd4, 32'hCAFE_F00D);
    for (int i = 0; i < 4; i++) access(1, 1, 0, RAM_BASE + 32'd4, 32'h0);
    access(1, 0, 1, PORT_OUT, 32'h0000_1234);
    access(1, 1, 0, PORT_OUT, 32'h0);
    idle(1, 1);

    idle(0, 4);
    chk32("queue_drained_ch0", 32'(q0.size()), 32'h0);
    chk32("queue_drained_ch1", 32'(q1.size()), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
